// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: PC path, instruction memory handshake and decode-side buffer port.
// The master modport is the fetch unit; the slave modport is its environment.
interface instr_fetch_unit_if;
   localparam int unsigned XLEN = 16;

   logic [XLEN-1:0] pc;
   logic            pc_inc;
   logic            mem_req;
   logic [XLEN-1:0] mem_addr;
   logic            mem_ack;
   logic [XLEN-1:0] mem_rdata;
   logic            flush;
   logic [XLEN-1:0] instr;
   logic [XLEN-1:0] instr_pc;
   logic            instr_valid;
   logic            instr_ready;
   logic            fetch_err;

   modport master (
      input  pc, mem_ack, mem_rdata, flush, instr_ready,
      output pc_inc, mem_req, mem_addr, instr, instr_pc, instr_valid, fetch_err
   );

   modport slave (
      output pc, mem_ack, mem_rdata, flush, instr_ready,
      input  pc_inc, mem_req, mem_addr, instr, instr_pc, instr_valid, fetch_err
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: req/ack memory read at the current PC, PC-advance pulse, PC-tagged buffer.
// Optional macro FETCH_TIMEOUT_EN adds an ack watchdog that raises a sticky fetch_err.
module instr_fetch_unit #(
   parameter int unsigned DEPTH   = 2,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic               i_clock,
   input  logic               i_reset,
   instr_fetch_unit_if.master bus
);
   localparam int unsigned XLEN  = 16;
   localparam int unsigned PTR_W = (DEPTH > 2) ? 2 : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   if (!((DEPTH == 2) || (DEPTH == 4)) || (TIMEOUT == 0) || (TIMEOUT > 255)) begin : g_param_check
      $error("instr_fetch_unit: DEPTH must be 2 or 4 and TIMEOUT 1..255");
   end

   typedef enum logic [1:0] {IDLE, REQ, ADV, DROP} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_start;
   logic             w_push;
   logic             w_pop;
   logic             w_pc_inc;
   logic             w_tmo_hit;
   logic             w_empty;
   logic             r_mem_req;
   logic [XLEN-1:0]  r_mem_addr;
   logic [XLEN-1:0]  r_buf_instr [DEPTH];
   logic [XLEN-1:0]  r_buf_pc    [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic [XLEN-1:0]  r_last_instr;
   logic [XLEN-1:0]  r_last_pc;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

`ifdef FETCH_TIMEOUT_EN
   logic [7:0] r_tmo_cnt;
   logic       r_fetch_err;

   assign w_tmo_hit = (r_tmo_cnt == 8'(TIMEOUT - 1)) && !bus.mem_ack;

   // Watchdog spans REQ and DROP; restarts on ack or when the wait ends
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_tmo_cnt   <= '0;
         r_fetch_err <= 1'b0;
      end else begin
         if (((r_state == REQ) || (r_state == DROP)) && !bus.mem_ack && !w_tmo_hit)
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
         else
            r_tmo_cnt <= '0;
         if (((r_state == REQ) || (r_state == DROP)) && w_tmo_hit)
            r_fetch_err <= 1'b1;
      end
   end

   assign bus.fetch_err = r_fetch_err;
`else
   assign w_tmo_hit     = 1'b0;
   assign bus.fetch_err = 1'b0;
`endif

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_push      = 1'b0;
      w_pc_inc    = 1'b0;
      case (r_state)
         IDLE: begin
            if (!bus.flush && (r_count < CNT_W'(DEPTH))) begin
               w_start     = 1'b1;
               w_state_nxt = REQ;
            end
         end
         REQ: begin
            if (bus.mem_ack) begin
               if (!bus.flush) begin
                  w_push      = 1'b1;
                  w_pc_inc    = 1'b1;
                  w_state_nxt = ADV;
               end else begin
                  w_state_nxt = IDLE;
               end
            end else if (w_tmo_hit) begin
               w_state_nxt = IDLE;
            end else if (bus.flush) begin
               w_state_nxt = DROP;
            end
         end
         // Outstanding read must still complete its handshake; its data is discarded
         DROP: begin
            if (bus.mem_ack || w_tmo_hit) w_state_nxt = IDLE;
         end
         ADV:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_mem_req  <= 1'b0;
         r_mem_addr <= '0;
      end else begin
         r_mem_req <= (w_state_nxt == REQ) || (w_state_nxt == DROP);
         if (w_start) r_mem_addr <= bus.pc;
      end
   end

   assign w_empty = (r_count == '0);
   assign w_pop   = bus.instr_ready && !w_empty && !bus.flush;

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (bus.flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clock) begin
      if (w_push) begin
         r_buf_instr[r_wr_ptr] <= bus.mem_rdata;
         r_buf_pc[r_wr_ptr]    <= r_mem_addr;
      end
   end

   // Remembers the last presented head so instr/instr_pc hold steady once empty
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_last_instr <= '0;
         r_last_pc    <= '0;
      end else if (!w_empty) begin
         r_last_instr <= r_buf_instr[r_rd_ptr];
         r_last_pc    <= r_buf_pc[r_rd_ptr];
      end
   end

   assign bus.instr       = w_empty ? r_last_instr : r_buf_instr[r_rd_ptr];
   assign bus.instr_pc    = w_empty ? r_last_pc    : r_buf_pc[r_rd_ptr];
   assign bus.instr_valid = !w_empty;
   assign bus.mem_req     = r_mem_req;
   assign bus.mem_addr    = r_mem_addr;
   assign bus.pc_inc      = w_pc_inc;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized memory latency, backpressure
// and flushes, checked against a queue-level model of the fetch buffer and PC path.
module tb_instr_fetch_unit;
   localparam int unsigned DEPTH   = 2;
   localparam int unsigned TIMEOUT = 4;

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] instr;
   } entry_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   instr_fetch_unit_if bus();

   instr_fetch_unit #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .i_clock (clk),
      .i_reset (rst_n),
      .bus     (bus)
   );

   entry_t      q[$];
   entry_t      obs_log[$];
   int          n_cmp = 0;
   int          n_mis = 0;
   int          cyc = 0;
   int          last_inc = -1;
   int          inc_count = 0;
   int          lat_max = 0;
   int          wait_cnt = 0;
   int          flush_pct = 0;
   int          fetch_idx = 0;
   bit          zw_phase = 0;
   bit          inc_pending = 0;
   bit          poisoned = 0;
   bit          prev_flush = 0;
   bit          ready_rand = 0;
   bit          ready_val = 0;
   bit          flush_force = 0;
   bit          target_fixed = 0;
   bit          use_seq = 0;
   bit          force_en = 0;
   logic [15:0] force_data = 16'h0;
   logic [15:0] flush_target = 16'h0;
   logic [15:0] pc_r = 16'h0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic reset_checks(input string t);
      check_eq({t, "_mem_req"},     32'(bus.mem_req),     32'd0);
      check_eq({t, "_mem_addr"},    32'(bus.mem_addr),    32'd0);
      check_eq({t, "_pc_inc"},      32'(bus.pc_inc),      32'd0);
      check_eq({t, "_instr_valid"}, 32'(bus.instr_valid), 32'd0);
      check_eq({t, "_instr"},       32'(bus.instr),       32'd0);
      check_eq({t, "_instr_pc"},    32'(bus.instr_pc),    32'd0);
      check_eq({t, "_fetch_err"},   32'(bus.fetch_err),   32'd0);
   endtask

   // Per-cycle reference: a fetch is accepted on an ack that is neither flushed nor stale
   task automatic model_cycle(input bit fl, input bit ack, input bit rdy, input logic [15:0] rd);
      bit     accept;
      entry_t e;
      accept = ack && !fl && !poisoned;
      check_eq("pc_inc", 32'(bus.pc_inc), 32'(accept));
      if (accept) check_eq("mem_addr", 32'(bus.mem_addr), 32'(pc_r));
      check_eq("instr_valid", 32'(bus.instr_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
         check_eq("instr",    32'(bus.instr),    32'(q[0].instr));
         check_eq("instr_pc", 32'(bus.instr_pc), 32'(q[0].pc));
      end
`ifndef FETCH_TIMEOUT_EN
      check_eq("fetch_err", 32'(bus.fetch_err), 32'd0);
`endif
      if (bus.pc_inc) begin
         if (last_inc >= 0) begin
            if (zw_phase) check_eq("pc_inc_gap", 32'(cyc - last_inc), 32'd3);
            else          check_eq("pc_inc_gap_min", 32'((cyc - last_inc) >= 3), 32'd1);
         end
         last_inc = cyc;
         inc_pending = 1;
         inc_count++;
      end
      if (bus.instr_valid && rdy && !fl) begin
         e.pc = bus.instr_pc;
         e.instr = bus.instr;
         obs_log.push_back(e);
      end
      if (fl && bus.mem_req && !ack) poisoned = 1;
      else if (ack)                  poisoned = 0;
      if (fl) begin
         q.delete();
      end else begin
         if (rdy && q.size() != 0) void'(q.pop_front());
         if (accept) begin
            e.pc = pc_r;
            e.instr = rd;
            q.push_back(e);
         end
      end
   endtask

   task automatic step();
      bit          fl;
      bit          ack;
      bit          rdy;
      logic [15:0] rd;
      @(posedge clk);
      #1;
      cyc++;
      if (inc_pending) pc_r = pc_r + 16'd2;
      inc_pending = 0;
      fl = flush_force || (int'($urandom_range(99)) < flush_pct);
      if (fl && !prev_flush) pc_r = target_fixed ? flush_target : (16'($urandom) & 16'hFFFE);
      ack = 0;
      rd = 16'($urandom);
      if (bus.mem_req) begin
         if (wait_cnt == 0) begin
            ack = 1;
            wait_cnt = int'($urandom_range(lat_max));
         end else begin
            wait_cnt--;
         end
      end
      if (ack) begin
         if (force_en) rd = force_data;
         else if (use_seq && fetch_idx < 3) rd = 16'(16'h1111 * (fetch_idx + 1));
         fetch_idx++;
      end
      rdy = ready_rand ? 1'($urandom_range(1)) : ready_val;
      bus.pc          = pc_r;
      bus.flush       = fl;
      bus.mem_ack     = ack;
      bus.mem_rdata   = rd;
      bus.instr_ready = rdy;
      @(negedge clk);
      model_cycle(fl, ack, rdy, rd);
      prev_flush = fl;
   endtask

   task automatic do_reset(input logic [15:0] new_pc);
      rst_n = 1'b0;
      pc_r = new_pc;
      bus.pc = new_pc;
      bus.flush = 1'b0;
      bus.mem_ack = 1'b0;
      bus.mem_rdata = 16'h0;
      bus.instr_ready = 1'b0;
      q.delete();
      inc_pending = 0;
      poisoned = 0;
      prev_flush = 0;
      last_inc = -1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_checks("rst");
      rst_n = 1'b1;
   endtask

   task automatic wait_until_req(input string tag);
      for (int i = 0; i < 20 && !bus.mem_req; i++) step();
      check_eq(tag, 32'(bus.mem_req), 32'd1);
   endtask

   initial begin
      // Reset abandons an in-flight request
      do_reset(16'h0010);
      wait_cnt = 1000;
      step();
      check_eq("req_after_rst", 32'(bus.mem_req), 32'd1);
      check_eq("addr_0010",     32'(bus.mem_addr), 32'h0010);
      step();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      reset_checks("mid_req");

      // Zero-wait memory, decode always ready
      do_reset(16'h0000);
      wait_cnt = 0;
      lat_max = 0;
      ready_val = 1;
      use_seq = 1;
      fetch_idx = 0;
      obs_log.delete();
      zw_phase = 1;
      step();
      check_eq("req_1cyc",  32'(bus.mem_req),  32'd1);
      check_eq("addr_0000", 32'(bus.mem_addr), 32'd0);
      repeat (12) step();
      zw_phase = 0;
      use_seq = 0;
      check_eq("zw_pop_count", 32'(obs_log.size() >= 3), 32'd1);
      for (int i = 0; i < 3; i++) begin
         if (i < obs_log.size()) begin
            check_eq("zw_instr", 32'(obs_log[i].instr), 32'(16'h1111 * (i + 1)));
            check_eq("zw_pc",    32'(obs_log[i].pc),    32'(2 * i));
         end
      end

      // Backpressure: buffer fills, then one pop admits one more fetch
      do_reset(16'h0000);
      ready_val = 0;
      wait_cnt = 0;
      inc_count = 0;
      repeat (15) step();
      check_eq("bp_fetches", 32'(inc_count),       32'd2);
      check_eq("bp_no_req",  32'(bus.mem_req),     32'd0);
      check_eq("bp_valid",   32'(bus.instr_valid), 32'd1);
      ready_val = 1;
      step();
      ready_val = 0;
      inc_count = 0;
      repeat (10) step();
      check_eq("bp_refetch",     32'(inc_count),   32'd1);
      check_eq("bp_no_req_again", 32'(bus.mem_req), 32'd0);

      // Flush mid-request: handshake completes, data discarded, restart at jump target
      wait_cnt = 1000;
      flush_force = 1;
      step();
      flush_force = 0;
      wait_until_req("req_before_flush");
      flush_force = 1;
      target_fixed = 1;
      flush_target = 16'h0040;
      wait_cnt = 3;
      force_en = 1;
      force_data = 16'hDEAD;
      step();
      flush_force = 0;
      target_fixed = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("drop_req_held", 32'(bus.mem_req),     32'd1);
         check_eq("flush_empty",   32'(bus.instr_valid), 32'd0);
      end
      force_en = 0;
      step();
      check_eq("drop_to_idle", 32'(bus.mem_req), 32'd0);
      wait_until_req("req_after_flush");
      check_eq("flush_new_addr", 32'(bus.mem_addr), 32'h0040);

      // Flush coinciding with ack while one entry is buffered
      wait_cnt = 1000;
      step();
      check_eq("one_buffered", 32'(bus.instr_valid), 32'd1);
      wait_until_req("req_before_fa");
      wait_cnt = 0;
      flush_force = 1;
      step();
      flush_force = 0;
      check_eq("fa_no_inc", 32'(bus.pc_inc), 32'd0);
      step();
      check_eq("fa_empty", 32'(bus.instr_valid), 32'd0);
      check_eq("fa_idle",  32'(bus.mem_req),     32'd0);

      // Randomized latency, backpressure and flushes
      lat_max = 3;
      wait_cnt = 0;
      flush_pct = 4;
      ready_rand = 1;
      repeat (3000) step();
      flush_pct = 0;
      ready_rand = 0;
      ready_val = 1;
      repeat (30) step();

`ifdef FETCH_TIMEOUT_EN
      begin
         int n;
         ready_val = 0;
         do_reset(16'h0100);
         wait_cnt = 1000;
         wait_until_req("req_before_tmo");
         n = 1;
         for (int i = 0; i < 20; i++) begin
            step();
            if (!bus.mem_req) break;
            n++;
         end
         check_eq("tmo_req_cycles", 32'(n),             32'(TIMEOUT));
         check_eq("tmo_err",        32'(bus.fetch_err), 32'd1);
         check_eq("tmo_req_drop",   32'(bus.mem_req),   32'd0);
         repeat (10) step();
         check_eq("tmo_err_sticky", 32'(bus.fetch_err), 32'd1);
         do_reset(16'h0000);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
